// File: rtl/act_bram_pipe.sv
// act_bram_pipe: in-place streaming activation over the conv feature-map BRAM.
// Reads port A sequentially, applies ReLU / leaky / clamp / bypass, writes the
// result back to the same address on port B, one element per clock.
// Optional build macro ACT_SAT_STATS_EN adds negative / saturation counters.
module act_bram_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 8,
  parameter int IMG_H       = 28,
  parameter int IMG_W       = 28,
  parameter int RD_LATENCY  = 1,
  parameter int LEAKY_SHIFT = 3,
  localparam int NUM_ELEMS  = CHANNELS * IMG_H * IMG_W,
  localparam int AW         = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] clamp_max,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         conv_r_addr,
  output logic                  conv_r_en,
  input  logic [DATA_WIDTH-1:0] conv_r_q,
  output logic [AW-1:0]         conv_w_addr,
  output logic                  conv_w_en,
  output logic                  conv_w_we,
  output logic [DATA_WIDTH-1:0] conv_w_d,
  output logic [AW:0]           neg_count,
  output logic [AW:0]           sat_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                        state, state_nxt;
  logic                          accept;
  logic [AW-1:0]                 rd_addr;
  logic [1:0]                    mode_q;
  logic signed [DATA_WIDTH-1:0]  cm_q;
  logic [RD_LATENCY-1:0]         pipe_v;
  logic [AW-1:0]                 pipe_a [RD_LATENCY];
  logic signed [DATA_WIDTH-1:0]  x;
  logic signed [DATA_WIDTH-1:0]  act;

  assign accept    = (state == IDLE) && start;
  assign x         = $signed(conv_r_q);
  assign conv_w_we = conv_w_en;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: drain ends when the final write is on the port this cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (conv_w_en && (conv_w_addr == LAST_ADDR)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from state
  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == FINISH);
    conv_r_en = (state == RUN);
  end

  assign conv_r_addr = rd_addr;

  // Read address sweep and per-pass configuration latch
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr <= '0;
      mode_q  <= '0;
      cm_q    <= '0;
    end else if (accept) begin
      rd_addr <= '0;
      mode_q  <= mode;
      cm_q    <= clamp_max[DATA_WIDTH-1] ? '0 : $signed(clamp_max);
    end else if ((state == RUN) && (rd_addr != LAST_ADDR)) begin
      rd_addr <= rd_addr + 1'b1;
    end
  end

  // Valid tracking matching the BRAM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= conv_r_en;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Address tracking alongside the valid bits
  always_ff @(posedge clk) begin
    pipe_a[0] <= rd_addr;
    for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_a[i] <= pipe_a[i-1];
  end

  // Activation function on the returning read data
  always_comb begin
    act = x;
    unique case (mode_q)
      2'd0: if (x < 0) act = '0;
      2'd1: if (x < 0) act = x >>> LEAKY_SHIFT;
      2'd2: begin
        if (x < 0)         act = '0;
        else if (x > cm_q) act = cm_q;
      end
      default: act = x;
    endcase
  end

  // Registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_w_en   <= 1'b0;
      conv_w_addr <= '0;
      conv_w_d    <= '0;
    end else begin
      conv_w_en <= pipe_v[RD_LATENCY-1];
      if (pipe_v[RD_LATENCY-1]) begin
        conv_w_addr <= pipe_a[RD_LATENCY-1];
        conv_w_d    <= act;
      end
    end
  end

`ifdef ACT_SAT_STATS_EN
  logic is_neg, is_sat;
  assign is_neg = (x < 0);
  assign is_sat = (mode_q == 2'd2) && !is_neg && (x > cm_q);

  // Statistics counted as each result is committed to the write register
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      neg_count <= '0;
      sat_count <= '0;
    end else if (pipe_v[RD_LATENCY-1]) begin
      if (is_neg) neg_count <= neg_count + 1'b1;
      if (is_sat) sat_count <= sat_count + 1'b1;
    end
  end
`else
  assign neg_count = '0;
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_act_bram_pipe.sv
// tb_act_bram_pipe: directed, table-driven bench for act_bram_pipe.
// Two instances: RD_LATENCY=1 and RD_LATENCY=3, each with a behavioural BRAM.
module tb_act_bram_pipe;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] cm = '0;

  logic        busy1, done1, re1, we1, wwe1, busy3, done3, re3, we3, wwe3;
  logic [4:0]  ra1, wa1, ra3, wa3;
  logic [15:0] q1, wd1, q3, wd3;
  logic [5:0]  neg1, sat1, neg3, sat3;

  logic [15:0] mem1 [N];
  logic [15:0] mem3 [N];
  logic [15:0] d3a, d3b;

  int nvec = 0;
  int nbad = 0;
  int g_done, g_writes, g_bad, g_neg, g_sat;

  typedef struct {
    int mode; int cm; int addr; int init; int exp; int eneg; int esat;
  } vec_t;
  vec_t vecs [20];

  always #5 clk = ~clk;

  act_bram_pipe #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_H(4), .IMG_W(4),
                  .RD_LATENCY(1), .LEAKY_SHIFT(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode), .clamp_max(cm),
    .busy(busy1), .done(done1), .conv_r_addr(ra1), .conv_r_en(re1), .conv_r_q(q1),
    .conv_w_addr(wa1), .conv_w_en(we1), .conv_w_we(wwe1), .conv_w_d(wd1),
    .neg_count(neg1), .sat_count(sat1));

  act_bram_pipe #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_H(4), .IMG_W(4),
                  .RD_LATENCY(3), .LEAKY_SHIFT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode), .clamp_max(cm),
    .busy(busy3), .done(done3), .conv_r_addr(ra3), .conv_r_en(re3), .conv_r_q(q3),
    .conv_w_addr(wa3), .conv_w_en(we3), .conv_w_we(wwe3), .conv_w_d(wd3),
    .neg_count(neg3), .sat_count(sat3));

  // BRAM models: read-before-write, latency 1 and 3
  always @(posedge clk) begin
    if (re1) q1 <= mem1[ra1];
    if (we1) mem1[wa1] = wd1;
  end

  always @(posedge clk) begin
    if (re3) d3a <= mem3[ra3];
    d3b <= d3a;
    q3  <= d3b;
    if (we3) mem3[wa3] = wd3;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic preload1();
    for (int k = 0; k < N; k++) mem1[k] = 16'(k - 16);
  endtask

  task automatic chk_stats(input int n, input int s, input int eneg, input int esat);
`ifdef ACT_SAT_STATS_EN
    chk("neg_count", n, eneg);
    chk("sat_count", s, esat);
`else
    chk("neg_count_tied", n, 0);
    chk("sat_count_tied", s, 0 * esat + 0 * eneg);
`endif
  endtask

  // One pass on the latency-1 instance; cycle 1 is the first read cycle
  task automatic run1(input logic [1:0] m, input logic [15:0] c);
    g_done = -1; g_writes = 0; g_bad = 0;
    @(negedge clk); mode = m; cm = c; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (busy1 !== (cyc <= 34)) g_bad++;
      if (re1 !== (cyc <= 32)) g_bad++;
      if (re1 && (int'(ra1) != cyc - 1)) g_bad++;
      if (we1 !== (cyc >= 3 && cyc <= 34)) g_bad++;
      if (we1) begin
        if (int'(wa1) != g_writes || wwe1 !== 1'b1) g_bad++;
        g_writes++;
      end
      if (done1) begin
        g_done = cyc; g_neg = neg1; g_sat = sat1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int i, j;
    vecs[0]  = '{1, 0, 0, -32768, -4096, 15, 0};
    vecs[1]  = '{1, 0, 1, -1, -1, 15, 0};
    vecs[2]  = '{1, 0, 2, -9, -2, 15, 0};
    vecs[3]  = '{1, 0, 3, 5, 5, 15, 0};
    vecs[4]  = '{1, 0, 8, -8, -1, 15, 0};
    vecs[5]  = '{1, 0, 20, 4, 4, 15, 0};
    vecs[6]  = '{2, 6, 5, -11, 0, 16, 9};
    vecs[7]  = '{2, 6, 16, 0, 0, 16, 9};
    vecs[8]  = '{2, 6, 19, 3, 3, 16, 9};
    vecs[9]  = '{2, 6, 22, 6, 6, 16, 9};
    vecs[10] = '{2, 6, 23, 7, 6, 16, 9};
    vecs[11] = '{2, 6, 31, 15, 6, 16, 9};
    vecs[12] = '{2, -5, 0, -16, 0, 16, 15};
    vecs[13] = '{2, -5, 16, 0, 0, 16, 15};
    vecs[14] = '{2, -5, 31, 15, 0, 16, 15};
    vecs[15] = '{3, 0, 0, -16, -16, 16, 0};
    vecs[16] = '{3, 0, 17, 1, 1, 16, 0};
    vecs[17] = '{0, 0, 3, -13, 0, 16, 0};
    vecs[18] = '{0, 0, 30, 14, 14, 16, 0};
    vecs[19] = '{0, 0, 15, -1, 0, 16, 0};

    preload1();
    for (int k = 0; k < N; k++) mem3[k] = 16'(k - 16);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);  chk("rst_done", done1, 0);
    chk("rst_r_en", re1, 0);    chk("rst_w_en", we1, 0);
    chk("rst_w_we", wwe1, 0);   chk("rst_r_addr", ra1, 0);
    chk("rst_w_addr", wa1, 0);  chk("rst_w_d", wd1, 0);
    chk("rst_neg", neg1, 0);    chk("rst_sat", sat1, 0);
    chk("rst_busy3", busy3, 0); chk("rst_w_en3", we3, 0);
    reset = 1'b0;

    // Mode 0 full pass: timing, busy window, write order, memory contents
    run1(2'd0, 16'd0);
    chk("m0_done_lat", g_done + 1, 35 + 1);
    chk("m0_timing", g_bad, 0);
    chk("m0_writes", g_writes, 32);
    for (int k = 0; k < N; k++)
      chk($sformatf("m0_mem[%0d]", k), int'($signed(mem1[k])), (k < 16) ? 0 : k - 16);
    chk_stats(g_neg, g_sat, 16, 0);
    @(negedge clk);
    chk("m0_done_pulse", done1, 0);

    // Table-driven vectors, grouped into one pass per mode/clamp setting
    i = 0;
    while (i < 20) begin
      preload1();
      j = i;
      while (j < 20 && vecs[j].mode == vecs[i].mode && vecs[j].cm == vecs[i].cm) begin
        mem1[vecs[j].addr] = 16'(vecs[j].init);
        j++;
      end
      run1(2'(vecs[i].mode), 16'(vecs[i].cm));
      chk($sformatf("tbl_done_m%0d", vecs[i].mode), g_done, 35);
      for (int k = i; k < j; k++)
        chk($sformatf("tbl_m%0d_a%0d", vecs[k].mode, vecs[k].addr),
            int'($signed(mem1[vecs[k].addr])), vecs[k].exp);
      chk_stats(g_neg, g_sat, vecs[i].eneg, vecs[i].esat);
      if (vecs[i].mode == 2 && vecs[i].cm < 0)
        for (int k = 0; k < N; k++)
          chk($sformatf("neg_cm_mem[%0d]", k), int'($signed(mem1[k])), 0);
      i = j;
    end

    // Latency-3 bypass pass with an ignored mid-pass start
    begin
      int hist_en [64];
      int hist_ad [64];
      int bad3, wr3, done3_cyc;
      bad3 = 0; wr3 = 0; done3_cyc = -1;
      @(negedge clk); mode = 2'd3; cm = 16'd0; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      for (int cyc = 1; cyc < 200; cyc++) begin
        if (cyc < 64) begin hist_en[cyc] = int'(re3); hist_ad[cyc] = int'(ra3); end
        if (busy3 !== (cyc <= 36)) bad3++;
        if (we3) begin
          if (cyc < 5 || cyc >= 64 || hist_en[cyc-4] != 1 || hist_ad[cyc-4] != int'(wa3)) bad3++;
          if (int'(wa3) != wr3 || wwe3 !== 1'b1) bad3++;
          wr3++;
        end
        if (done3) begin done3_cyc = cyc; break; end
        if (cyc == 10) begin start3 = 1'b1; mode = 2'd0; cm = 16'd2; end
        @(negedge clk);
        start3 = 1'b0;
      end
      chk("l3_done_lat", done3_cyc, 37);
      chk("l3_addr_trail", bad3, 0);
      chk("l3_writes", wr3, 32);
      for (int k = 0; k < N; k++)
        chk($sformatf("l3_mem[%0d]", k), int'($signed(mem3[k])), k - 16);
      @(negedge clk);
      chk("l3_no_restart", busy3, 0);
    end

    // Reset ten cycles into a mode 0 pass, then a clean rerun
    preload1();
    @(negedge clk); mode = 2'd0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_r_en", re1, 0);  chk("mid_rst_w_en", we1, 0);
    chk("mid_rst_busy", busy1, 0); chk("mid_rst_done", done1, 0);
    reset = 1'b0;
    begin
      int ndone = 0;
      repeat (40) begin
        @(negedge clk);
        if (done1 || busy1) ndone++;
      end
      chk("mid_rst_quiet", ndone, 0);
    end
    chk("mid_rst_partial", int'($signed(mem1[20])), 4);
    run1(2'd0, 16'd0);
    chk("rerun_done_lat", g_done, 35);
    chk("rerun_timing", g_bad, 0);
    for (int k = 0; k < N; k++)
      chk($sformatf("rerun_mem[%0d]", k), int'($signed(mem1[k])), (k < 16) ? 0 : k - 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
